// File: rtl/permutation_ctrl.sv
// permutation_ctrl: iterative ASCON permutation controller.
// Holds the 320-bit state, presents the round index, applies one round
// (constant addition, S-box layer, linear diffusion) per cycle and signals
// completion with a one-cycle done pulse.
// Optional build macro PERM_UNROLL2_EN: two chained rounds per cycle.
module permutation_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic [3:0]       round_o,
    output logic             busy_o,
    output logic             done_o
);

    // word 0 is x0 (S-box MSB) ... word 4 is x4
    typedef logic [4:0][63:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

`ifdef PERM_UNROLL2_EN
    localparam logic [3:0] STEP = 4'd2;
    localparam logic [3:0] LAST = 4'd10;  // pair (10,11) is the final one
`else
    localparam logic [3:0] STEP = 4'd1;
    localparam logic [3:0] LAST = 4'd11;
`endif

    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

    fsm_t   fsm;
    state_t round_next;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One full ASCON round on the bitsliced state.
    function automatic state_t round_fn(input state_t s, input logic [3:0] r);
        state_t      x;
        logic [63:0] t0, t1, t2, t3, t4;
        x = s;
        // round constant ((0xF-r)<<4)|r into the low byte of x2
        x[2][7:0] = x[2][7:0] ^ {4'hF - r, r};
        // S-box layer, bitsliced form
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t0 = ~x[0] & x[1];
        t1 = ~x[1] & x[2];
        t2 = ~x[2] & x[3];
        t3 = ~x[3] & x[4];
        t4 = ~x[4] & x[0];
        x[0] = x[0] ^ t1;
        x[1] = x[1] ^ t2;
        x[2] = x[2] ^ t3;
        x[3] = x[3] ^ t4;
        x[4] = x[4] ^ t0;
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        // linear diffusion layer
        x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return x;
    endfunction

    // Combinational round datapath between state register output and input.
    always_comb begin
`ifdef PERM_UNROLL2_EN
        round_next = round_fn(round_fn(state_o, round_o), round_o + 4'd1);
`else
        round_next = round_fn(state_o, round_o);
`endif
    end

    // Control FSM with registered state, round counter and status outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            state_o <= '0;
            round_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_o <= state_i;
                        round_o <= mode_i ? START_B : START_A;
                        busy_o  <= 1'b1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_o <= round_next;
                    if (round_o == LAST) begin
                        // counter holds at the last index, never wraps
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        fsm    <= DONE;
                    end else begin
                        round_o <= round_o + STEP;
                    end
                end
                DONE: begin
                    // start_i is deliberately ignored here
                    done_o <= 1'b0;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Bench for permutation_ctrl: table of p^a/p^b vectors with expected states
// from an S-box lookup-table model, plus reset, start-while-busy, held-start
// and reset-mid-run sequences.
module tb_permutation_ctrl;

    typedef logic [4:0][63:0] st_t;

`ifdef PERM_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int RA = 12;
    localparam int RB = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    st_t         din;
    st_t         dout;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    permutation_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clock_i (clk),
        .resetb_i(rst_n),
        .start_i (start),
        .mode_i  (mode),
        .state_i (din),
        .state_o (dout),
        .round_o (round),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    // ASCON 5-bit S-box, index bit 4 = x0 ... bit 0 = x4
    function automatic logic [4:0] sbox5(input logic [4:0] i);
        case (i)
            5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
            5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
            5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic st_t golden(input st_t s_in, input int nr);
        st_t        s, t;
        logic [4:0] o;
        s = s_in;
        for (int r = 12 - nr; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                o = sbox5({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
                t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2];
                t[3][b] = o[1]; t[4][b] = o[0];
            end
            s[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
            s[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
            s[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
            s[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
            s[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic mode;
        st_t  din;
        st_t  exp;
        int   inject;   // RUN cycle at which a stray start is issued (0 = none)
    } vec_t;

    vec_t tbl[5];
    st_t  spec_in, alt_in, zero_in;

    // Run one table vector and check every cycle of the transaction.
    task automatic run_vec(input int idx);
        int         nr, n, first, last;
        logic [5:0] exp_st;
        nr    = tbl[idx].mode ? RB : RA;
        n     = nr / STEP;
        first = 12 - nr;
        last  = 12 - STEP;
        @(negedge clk);
        start = 1'b1; mode = tbl[idx].mode; din = tbl[idx].din;
        @(negedge clk);  // start accepted at edge k
        start = 1'b0; mode = ~tbl[idx].mode; din = alt_in;
        chk($sformatf("v%0d_c0", idx), {314'd0, round, busy, done}, {314'd0, 4'(first), 2'b10});
        for (int j = 1; j <= n; j++) begin
            if (j == tbl[idx].inject) begin
                start = 1'b1; din = alt_in;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (j < n) exp_st = {4'(first + j * STEP), 2'b10};
            else       exp_st = {4'(last), 2'b01};
            chk($sformatf("v%0d_c%0d", idx, j), {314'd0, round, busy, done}, {314'd0, exp_st});
        end
        start = 1'b0;
        chk($sformatf("v%0d_state", idx), dout, tbl[idx].exp);
        @(negedge clk);
        chk($sformatf("v%0d_after", idx), {dout, busy, done}, {tbl[idx].exp, 2'b00});
    endtask

    initial begin
        int seen;
        int nb;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; din = '0;

        spec_in[0] = 64'h80400c0600000000;
        spec_in[1] = 64'h0001020304050607;
        spec_in[2] = 64'h08090a0b0c0d0e0f;
        spec_in[3] = 64'h0011223344556677;
        spec_in[4] = 64'h8899aabbccddeeff;
        alt_in[0]  = 64'hdeadbeefcafef00d;
        alt_in[1]  = 64'h0123456789abcdef;
        alt_in[2]  = 64'hfedcba9876543210;
        alt_in[3]  = 64'h5555aaaa5555aaaa;
        alt_in[4]  = 64'h00000000ffffffff;
        zero_in    = '0;

        tbl[0] = '{mode: 1'b0, din: spec_in, exp: golden(spec_in, RA), inject: 0};
        tbl[1] = '{mode: 1'b1, din: spec_in, exp: golden(spec_in, RB), inject: 0};
        tbl[2] = '{mode: 1'b0, din: alt_in,  exp: golden(alt_in,  RA), inject: 0};
        tbl[3] = '{mode: 1'b1, din: zero_in, exp: golden(zero_in, RB), inject: 0};
        tbl[4] = '{mode: 1'b0, din: spec_in, exp: golden(spec_in, RA), inject: 3};

        // reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_state", dout, '0);
        chk("rst_round", {316'd0, round}, 320'd0);
        chk("rst_busy",  {319'd0, busy},  320'd0);
        chk("rst_done",  {319'd0, done},  320'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), {dout, round, busy, done}, 320'd0);
        end

        // table-driven vectors (entry 4 carries a start while busy)
        for (int i = 0; i < 5; i++) run_vec(i);

        // start held high: ignored in RUN and DONE, accepted in following IDLE
        nb = RB / STEP;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; din = alt_in;
        @(negedge clk);
        repeat (nb) @(negedge clk);
        chk("hold_done", {dout, busy, done}, {golden(alt_in, RB), 2'b01});
        @(negedge clk);
        chk("hold_in_done", {dout, busy, done}, {golden(alt_in, RB), 2'b00});
        @(negedge clk);
        chk("hold_reaccept", {dout, round, busy, done}, {alt_in, 4'(12 - RB), 2'b10});
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("hold_second_done", {319'd0, 1'(seen)}, 320'd1);
        chk("hold_second_state", dout, golden(alt_in, RB));

        // reset asserted mid p^a
        @(negedge clk);
        start = 1'b1; mode = 1'b0; din = spec_in;
        @(negedge clk);
        start = 1'b0;
        repeat (5 / STEP) @(negedge clk);
        chk("mid_round", {316'd0, round}, {316'd0, 4'((5 / STEP) * STEP)});
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_async", {dout, round, busy, done}, 320'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("mid_no_done", {288'd0, 32'(seen)}, 320'd0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
